matmul_apb_master: RTL and testbench
====================================

// Module: matmul_apb_master
// PURPOSE
//  APB initiator that drives the matmul accelerator's slave port (psel/penable/pready/pslverr).
//  Accepts single read/write commands on a valid/ready channel and runs one APB SETUP+ACCESS transfer per command.
//  Returns read data and error status on a valid/ready response channel.
//  Used by the bench sequencer and by on-chip host logic; one transfer outstanding at a time.
// PARAMETERS
//  ADDR_WIDTH      16   APB address width (paddr)
//  BUS_WIDTH       64   APB data width (pwdata/prdata)
//  TIMEOUT_CYCLES  256  max ACCESS cycles waiting for pready; 0 = no timeout
//  ERRCNT_WIDTH    16   width of saturating error counter
// PORTS
//  clk          in   1               clock, all logic on posedge
//  rst_n        in   1               synchronous active-low reset
//  cmd_valid    in   1               command present
//  cmd_ready    out  1               command accepted when cmd_valid&&cmd_ready
//  cmd_write    in   1               1=write, 0=read
//  cmd_addr     in   ADDR_WIDTH      target address
//  cmd_wdata    in   BUS_WIDTH       write data
//  cmd_strb     in   BUS_WIDTH/8     byte strobes (writes only)
//  rsp_valid    out  1               response present
//  rsp_ready    in   1               response consumed when rsp_valid&&rsp_ready
//  rsp_rdata    out  BUS_WIDTH       read data (0 for writes and timeouts)
//  rsp_err      out  1               pslverr seen or timeout
//  rsp_timeout  out  1               transfer aborted by timeout
//  err_count    out  ERRCNT_WIDTH    saturating count of rsp_err responses
//  psel penable pwrite  out 1        APB control
//  paddr        out  ADDR_WIDTH      APB address
//  pwdata       out  BUS_WIDTH       APB write data
//  pstrb        out  BUS_WIDTH/8     APB strobes
//  prdata       in   BUS_WIDTH       APB read data
//  pready       in   1               APB ready
//  pslverr      in   1               APB slave error
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata,
//   rsp_err, rsp_timeout, err_count and the timeout counter all 0. Reset mid-transfer drops psel/penable next cycle.
//   No response is produced for the aborted transfer.
//  FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//   IDLE: cmd_ready=1 (combinational, state==IDLE only). On accept, register write/addr/wdata/strb -> SETUP.
//   SETUP: psel=1, penable=0, address, control and data stable. Always one cycle -> ACCESS.
//   ACCESS: psel=1, penable=1, outputs held. pready=1 at posedge completes the transfer.
//    Capture rsp_rdata=prdata for reads, else 0. rsp_err=pslverr -> RESP; psel/penable=0 from the next cycle.
//   RESP: rsp_valid=1, response fields held stable until rsp_ready=1 -> IDLE.
//  pstrb is driven as cmd_strb for writes and forced to 0 for reads.
//  Minimum latency: accept at T; SETUP T+1; ACCESS T+2; rsp_valid T+3 with zero wait states.
//   Each pready-low cycle in ACCESS adds 1.
//  Timeout: counter clears on entering ACCESS and increments each ACCESS cycle with pready=0.
//   When TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 with pready=0, abort -> RESP with
//   rsp_err=1, rsp_timeout=1, rsp_rdata=0.
//   pready and timeout in the same cycle: pready wins and the transfer is a normal completion.
//  err_count increments by 1 on the RESP entry cycle when rsp_err=1 and saturates at all-ones.
//  cmd_valid while not IDLE is ignored (cmd_ready=0). The command is not buffered.
//  pslverr is sampled only in ACCESS with pready=1 and ignored elsewhere.
// TESTING
//  1 write addr 0x0 data 0x1 strb 0xFF, pready tied 1 -> psel T+1, penable T+2, rsp_valid T+3, rsp_err=0.
//  2 read addr 0x10, pready low 3 cycles then 1 with prdata=0xDEAD -> rsp_valid T+6, rsp_rdata=0xDEAD, pstrb=0.
//  3 write while slave busy, pslverr=1 with pready=1 -> rsp_err=1, rsp_timeout=0, err_count 0->1.
//  4 TIMEOUT_CYCLES=4, pready held 0 -> abort after 4 ACCESS cycles, rsp_timeout=1, rsp_rdata=0, psel dropped.
//  5 rst_n=0 in ACCESS -> next cycle psel=0, penable=0, cmd_ready=1 after release, no rsp_valid.
//  6 two queued commands, rsp_ready held 0 for 5 cycles -> cmd_ready stays 0, response stable;
//    second command is accepted only after the handshake.

Source files
------------

// File: rtl/matmul_apb_master.sv
// APB initiator for the matmul accelerator slave port.
// Runs one SETUP+ACCESS transfer per command and returns data/error on a response channel.
module matmul_apb_master #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned BUS_WIDTH      = 64,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned ERRCNT_WIDTH   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [BUS_WIDTH-1:0]      cmd_wdata,
    input  logic [BUS_WIDTH/8-1:0]    cmd_strb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [BUS_WIDTH-1:0]      rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic [ERRCNT_WIDTH-1:0]   err_count,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_WIDTH-1:0]     paddr,
    output logic [BUS_WIDTH-1:0]      pwdata,
    output logic [BUS_WIDTH/8-1:0]    pstrb,
    input  logic [BUS_WIDTH-1:0]      prdata,
    input  logic                      pready,
    input  logic                      pslverr
);

    localparam int unsigned STRB_W = BUS_WIDTH / 8;
    localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e                    state_q;
    logic                      psel_q;
    logic                      penable_q;
    logic                      pwrite_q;
    logic [ADDR_WIDTH-1:0]     paddr_q;
    logic [BUS_WIDTH-1:0]      pwdata_q;
    logic [STRB_W-1:0]         pstrb_q;
    logic                      rsp_valid_q;
    logic [BUS_WIDTH-1:0]      rsp_rdata_q;
    logic                      rsp_err_q;
    logic                      rsp_timeout_q;
    logic [ERRCNT_WIDTH-1:0]   err_count_q;
    logic [ERRCNT_WIDTH-1:0]   err_count_d;
    logic [CNT_W-1:0]          tcnt_q;
    logic                      timeout_hit;

    // Saturating increment and timeout detect for the current ACCESS cycle.
    always_comb begin
        err_count_d = (err_count_q == '1) ? err_count_q
                                          : err_count_q + ERRCNT_WIDTH'(1);
        timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt_q == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            err_count_q   <= '0;
            tcnt_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        state_q  <= SETUP;
                        psel_q   <= 1'b1;
                        pwrite_q <= cmd_write;
                        paddr_q  <= cmd_addr;
                        pwdata_q <= cmd_wdata;
                        pstrb_q  <= cmd_write ? cmd_strb : '0;
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                    tcnt_q    <= '0;
                end
                ACCESS: begin
                    // pready takes priority over a timeout in the same cycle.
                    if (pready) begin
                        state_q       <= RESP;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= pwrite_q ? '0 : prdata;
                        rsp_err_q     <= pslverr;
                        rsp_timeout_q <= 1'b0;
                        if (pslverr) begin
                            err_count_q <= err_count_d;
                        end
                    end else if (timeout_hit) begin
                        state_q       <= RESP;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= '0;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        err_count_q   <= err_count_d;
                    end else begin
                        tcnt_q <= tcnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_matmul_apb_master.sv
// Bench for matmul_apb_master: random commands against a reactive APB slave,
// responses checked by a scoreboard monitor against transaction-level expectations.
module tb_matmul_apb_master;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 64;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned TO = 4;
    localparam int unsigned EW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic [EW-1:0] err_count;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    matmul_apb_master #(
        .ADDR_WIDTH(AW), .BUS_WIDTH(DW), .TIMEOUT_CYCLES(TO), .ERRCNT_WIDTH(EW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .err_count(err_count),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
        .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    // One command plus how the slave will answer it.
    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        int unsigned   w;
        logic          perr;
        logic [DW-1:0] rdata;
        longint        acc;
    } txn_t;

    txn_t   exp_q[$];
    txn_t   slv_q[$];
    int     vectors     = 0;
    int     miscompares = 0;
    longint cyc         = 0;
    int     hold        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // APB slave: answers each ACCESS phase after the transaction's wait count.
    initial begin
        bit          s_act = 0;
        int unsigned s_cnt = 0;
        txn_t        s_cur;
        s_cur   = '{default: '0};
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
        forever begin
            @(negedge clk);
            if (psel && penable) begin
                if (!s_act) begin
                    s_act = 1;
                    s_cnt = 0;
                    if (slv_q.size() != 0) s_cur = slv_q.pop_front();
                end else begin
                    s_cnt++;
                end
                if (s_cnt == s_cur.w) begin
                    pready  = 1'b1;
                    prdata  = s_cur.rdata;
                    pslverr = s_cur.perr;
                end else begin
                    pready  = 1'b0;
                    prdata  = {$urandom, $urandom};
                    pslverr = 1'($urandom);
                end
            end else begin
                s_act   = 0;
                pready  = 1'($urandom);
                prdata  = {$urandom, $urandom};
                pslverr = 1'($urandom);
            end
        end
    end

    // Response back-pressure, including occasional 5-cycle stalls.
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold > 0) begin
                rsp_ready = 1'b0;
                hold--;
            end else if ($urandom_range(0, 9) == 0) begin
                rsp_ready = 1'b0;
                hold = 4;
            end else begin
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        bit            in_rsp = 0;
        int unsigned   ecnt_m = 0;
        txn_t          t;
        bit            to;
        bit            er;
        logic [DW-1:0] rd;
        logic [DW-1:0] h_rdata;
        logic          h_err;
        logic          h_to;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_rsp = 0;
                ecnt_m = 0;
            end else begin
                if (psel && exp_q.size() != 0) begin
                    t = exp_q[0];
                    chk("paddr", 64'(paddr), 64'(t.addr));
                    chk("pwrite", 64'(pwrite), 64'(t.wr));
                    chk("pstrb", 64'(pstrb), t.wr ? 64'(t.strb) : 64'd0);
                    if (t.wr) chk("pwdata", pwdata, t.wdata);
                end
                if (rsp_valid) begin
                    chk("cmd_ready_in_resp", 64'(cmd_ready), 64'd0);
                    if (!in_rsp) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_rsp", 64'd1, 64'd0);
                        end else begin
                            t  = exp_q.pop_front();
                            to = (t.w >= TO);
                            er = to || t.perr;
                            rd = (!to && !t.wr) ? t.rdata : '0;
                            if (er && ecnt_m < (1 << EW) - 1) ecnt_m++;
                            chk("rsp_rdata", rsp_rdata, rd);
                            chk("rsp_err", 64'(rsp_err), 64'(er));
                            chk("rsp_timeout", 64'(rsp_timeout), 64'(to));
                            chk("latency", 64'(cyc - t.acc), to ? 64'(TO + 1) : 64'(t.w + 2));
                            chk("err_count", 64'(err_count), 64'(ecnt_m));
                            chk("psel_dropped", 64'(psel), 64'd0);
                        end
                        h_rdata = rsp_rdata;
                        h_err   = rsp_err;
                        h_to    = rsp_timeout;
                        in_rsp  = 1;
                    end else begin
                        chk("rsp_stable", {rsp_rdata[61:0], rsp_err, rsp_timeout},
                            {h_rdata[61:0], h_err, h_to});
                    end
                    if (rsp_ready) in_rsp = 0;
                end
            end
        end
    end

    task automatic issue(input txn_t t_in);
        txn_t t = t_in;
        int   n = 0;
        cmd_valid = 1'b1;
        cmd_write = t.wr;
        cmd_addr  = t.addr;
        cmd_wdata = t.wdata;
        cmd_strb  = t.strb;
        while (!cmd_ready) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL accept_bound: cmd_ready got 0 expected 1 within 200 cycles");
                cmd_valid = 1'b0;
                return;
            end
        end
        t.acc = cyc + 1;
        exp_q.push_back(t);
        slv_q.push_back(t);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_wdata = {$urandom, $urandom};
        cmd_strb  = SW'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    function automatic txn_t mk(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                input logic [SW-1:0] s, input int unsigned w, input logic pe,
                                input logic [DW-1:0] rd);
        txn_t t;
        t.wr = wr; t.addr = a; t.wdata = wd; t.strb = s;
        t.w = w; t.perr = pe; t.rdata = rd; t.acc = 0;
        return t;
    endfunction

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 || rsp_valid) begin
            @(negedge clk);
            n++;
            if (n > 3000) begin
                vectors++;
                miscompares++;
                $display("FAIL drain_bound: %0d responses outstanding expected 0", exp_q.size());
                exp_q.delete();
                return;
            end
        end
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        repeat (3) @(negedge clk);
        chk("rst_psel", 64'(psel), 64'd0);
        chk("rst_penable", 64'(penable), 64'd0);
        chk("rst_pwrite", 64'(pwrite), 64'd0);
        chk("rst_paddr", 64'(paddr), 64'd0);
        chk("rst_pwdata", pwdata, 64'd0);
        chk("rst_pstrb", 64'(pstrb), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_fields", {rsp_rdata[61:0], rsp_err, rsp_timeout}, 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);

        issue(mk(1'b1, 16'h0000, 64'h1, 8'hFF, 0, 1'b0, 64'h0));
        issue(mk(1'b0, 16'h0010, 64'h55, 8'hA5, 3, 1'b0, 64'hDEAD));
        issue(mk(1'b1, 16'h0020, 64'hCAFE, 8'h0F, 1, 1'b1, 64'h0));
        issue(mk(1'b0, 16'h0030, 64'h0, 8'hFF, 9, 1'b0, 64'h1234));
        for (int i = 0; i < 250; i++) begin
            issue(mk(1'($urandom), AW'($urandom), {$urandom, $urandom}, SW'($urandom),
                     $urandom_range(0, 6), ($urandom_range(0, 3) == 0), {$urandom, $urandom}));
        end
        drain();

        // Reset while the slave is stalling in ACCESS.
        issue(mk(1'b0, 16'h0040, 64'h0, 8'hFF, 20, 1'b0, 64'hBEEF));
        n = 0;
        while (!(psel && penable) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reached_access", 64'(psel && penable), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_psel", 64'(psel), 64'd0);
        chk("rst_mid_penable", 64'(penable), 64'd0);
        chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_mid_err_count", 64'(err_count), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        repeat (8) begin
            @(negedge clk);
            chk("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
        end

        issue(mk(1'b1, 16'h0050, 64'h77, 8'h3C, 2, 1'b0, 64'h0));
        issue(mk(1'b0, 16'h0060, 64'h0, 8'hFF, 3, 1'b1, 64'hF00D));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
